selen_l1_mem_arb: RTL and testbench
===================================

# selen_l1_mem_arb

Two-port arbiter that shares the single memory port of the CPU cluster between the L1 instruction cache (I-side, read-only refills) and the L1 data cache (D-side, reads and writes). It sits between `l1i`/`l1d` and the memory interface inside the L1 cache wrapper. It grants one transaction at a time using round-robin priority, registers the winning request, and routes the memory response back to the owning cache.

## Interface
Parameters:
- `ADDR_W`, 32, request address width
- `DATA_W`, 32, data width; `DATA_W/8` byte enables

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `i_req_val`  in  1  I-side request valid
- `i_req_ack`  out  1  I-side request accepted
- `i_req_addr`  in  ADDR_W  I-side read address
- `i_rsp_val`  out  1  I-side response valid, one-cycle pulse
- `i_rsp_data`  out  DATA_W  I-side read data
- `d_req_val`  in  1  D-side request valid
- `d_req_ack`  out  1  D-side request accepted
- `d_req_addr`  in  ADDR_W  D-side address
- `d_req_we`  in  1  D-side write enable
- `d_req_be`  in  DATA_W/8  D-side byte enables
- `d_req_wdata`  in  DATA_W  D-side write data
- `d_rsp_val`  out  1  D-side response valid, one-cycle pulse; also acknowledges writes
- `d_rsp_data`  out  DATA_W  D-side read data
- `mem_req_val`  out  1  memory request valid
- `mem_req_ack`  in  1  memory accepted request
- `mem_req_addr`, `mem_req_we`, `mem_req_be`, `mem_req_wdata`  out  ADDR_W/1/DATA_W/8/DATA_W  registered request fields
- `mem_rsp_val`  in  1  memory response valid, one-cycle pulse
- `mem_rsp_data`  in  DATA_W  memory read data
- `busy`  out  1  transaction in flight (state != IDLE)
- `owner`  out  1  owner of the current or last transaction: 0 = I, 1 = D

## Operation
- FSM states: IDLE, REQ, RSP.
- IDLE:
  - If `i_req_val` or `d_req_val` is high, pick a winner.
  - Only one requester valid: that one wins. Both valid: the side not granted last wins.
  - `x_req_ack` is combinational: 1 only in IDLE, only for the winner.
  - On that edge, latch addr/we/be/wdata into the request registers. The I-side forces we=0 and be=all ones.
  - Set `owner` = winner and go to REQ.
- REQ: `mem_req_val`=1 with the registered fields, which stay stable. On `mem_req_ack`=1, go to RSP.
- RSP:
  - Wait for `mem_rsp_val`.
  - On that cycle, the owner's `x_rsp_val` = 1 (combinational pass-through) and `x_rsp_data` = `mem_rsp_data`.
  - The other side's `rsp_val` stays 0. Go to IDLE.
- `last_grant` updates at acceptance; its reset value is D, so the I-side wins the first tie.
- Requesters hold val and fields stable until ack. The arbiter never drops or reorders an accepted request.
- `mem_rsp_val` outside RSP is a protocol error and is ignored. Memory returns the response at least one cycle after `mem_req_ack`.
- Write responses carry undefined `rsp_data`; requesters ignore it.

## Timing
- Reset values, applied asynchronously:
  - state=IDLE, `last_grant`=D, `owner`=0.
  - Request registers are 0, and `mem_req_val`=0.
  - Both `rsp_val`=0, `busy`=0. `x_req_ack` follows IDLE decode.
- Reset mid-transaction: the FSM returns to IDLE immediately and the in-flight transaction is discarded. The memory side is reset by the same `rst_n`.
- Minimum transaction: accept at cycle 0, `mem_req_val` in cycle 1, ack in cycle 1, response in cycle 2, next accept in cycle 3. Throughput is one transaction per 3 cycles with a zero-wait memory.
- A new request is never accepted on the same cycle as a response; the FSM passes through IDLE first.
- A requester that deasserts val before ack loses nothing; no grant is issued to it.

## Test plan
- Reset, I-side read of addr 0x100, memory acks in 1 cycle and returns 0xDEADBEEF 2 cycles later:
  - `i_req_ack` pulses in the first cycle.
  - `mem_req_addr`=0x100, we=0, be=0xF.
  - `i_rsp_val` carries 0xDEADBEEF; `d_rsp_val` stays 0.
- D-side write of 0xA5A5A5A5 to 0x200 with be=0x3:
  - Memory sees we=1, be=0x3, wdata=0xA5A5A5A5.
  - `d_rsp_val` pulses once on the memory response.
- Both sides request continuously for 4 transactions starting from reset: grants go I, D, I, D, and each response reaches the correct side.
- Memory stalls `mem_req_ack` for 10 cycles:
  - `mem_req_val` and the fields stay stable.
  - `busy`=1.
  - No second `req_ack` is issued.
- `rst_n` asserted in RSP, then a new I-side request: the in-flight response is never delivered, and the new request is accepted with `last_grant` back at its reset value.
- Spurious `mem_rsp_val` in IDLE: no `rsp_val` is produced on either side.

Source files
------------

// File: rtl/selen_l1_mem_arb_if.sv
// Bus bundle between the L1 I/D caches, the arbiter and the memory port.
// master = arbiter view, slave = caches plus memory view.
interface selen_l1_mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              i_req_val;
  logic              i_req_ack;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_rsp_val;
  logic [DATA_W-1:0] i_rsp_data;

  logic              d_req_val;
  logic              d_req_ack;
  logic [ADDR_W-1:0] d_req_addr;
  logic              d_req_we;
  logic [BE_W-1:0]   d_req_be;
  logic [DATA_W-1:0] d_req_wdata;
  logic              d_rsp_val;
  logic [DATA_W-1:0] d_rsp_data;

  logic              mem_req_val;
  logic              mem_req_ack;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_we;
  logic [BE_W-1:0]   mem_req_be;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_rsp_val;
  logic [DATA_W-1:0] mem_rsp_data;

  logic              busy;
  logic              owner;

  modport master (
    input  i_req_val, i_req_addr,
    output i_req_ack, i_rsp_val, i_rsp_data,
    input  d_req_val, d_req_addr, d_req_we,
    input  d_req_be, d_req_wdata,
    output d_req_ack, d_rsp_val, d_rsp_data,
    output mem_req_val, mem_req_addr, mem_req_we,
    output mem_req_be, mem_req_wdata,
    input  mem_req_ack, mem_rsp_val, mem_rsp_data,
    output busy, owner
  );

  modport slave (
    output i_req_val, i_req_addr,
    input  i_req_ack, i_rsp_val, i_rsp_data,
    output d_req_val, d_req_addr, d_req_we,
    output d_req_be, d_req_wdata,
    input  d_req_ack, d_rsp_val, d_rsp_data,
    input  mem_req_val, mem_req_addr, mem_req_we,
    input  mem_req_be, mem_req_wdata,
    output mem_req_ack, mem_rsp_val, mem_rsp_data,
    input  busy, owner
  );
endinterface

// File: rtl/selen_l1_mem_arb.sv
// Round-robin arbiter sharing one memory port between L1 I and L1 D.
// One transaction in flight; the winning request is held in registers.
module selen_l1_mem_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  selen_l1_mem_arb_if.master bus
);

  localparam int   BE_W   = DATA_W / 8;
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } state_e;

  state_e state_q, state_d;

  logic last_q, last_d;
  logic owner_q, owner_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic any_req;
  logic win;
  logic accept;

  // On a tie the side not granted last wins
  always_comb begin
    any_req = bus.i_req_val | bus.d_req_val;
    win     = (bus.i_req_val & bus.d_req_val)
            ? ~last_q
            : bus.d_req_val;
    accept  = (state_q == IDLE) & any_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= SIDE_D;
      owner_q <= SIDE_I;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) state_d = REQ;
      end
      REQ: begin
        if (bus.mem_req_ack) state_d = RSP;
      end
      RSP: begin
        if (bus.mem_rsp_val) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture; I-side refills are full-word reads
  always_comb begin
    last_d  = last_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    if (accept) begin
      last_d  = win;
      owner_d = win;
      unique case (1'b1)
        win: begin
          addr_d  = bus.d_req_addr;
          we_d    = bus.d_req_we;
          be_d    = bus.d_req_be;
          wdata_d = bus.d_req_wdata;
        end
        !win: begin
          addr_d  = bus.i_req_addr;
          we_d    = 1'b0;
          be_d    = '1;
          wdata_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.i_req_ack     = accept & (win == SIDE_I);
    bus.d_req_ack     = accept & (win == SIDE_D);
    bus.mem_req_val   = (state_q == REQ);
    bus.mem_req_addr  = addr_q;
    bus.mem_req_we    = we_q;
    bus.mem_req_be    = be_q;
    bus.mem_req_wdata = wdata_q;
    bus.i_rsp_val     = (state_q == RSP)
                      & bus.mem_rsp_val
                      & (owner_q == SIDE_I);
    bus.d_rsp_val     = (state_q == RSP)
                      & bus.mem_rsp_val
                      & (owner_q == SIDE_D);
    bus.i_rsp_data    = bus.mem_rsp_data;
    bus.d_rsp_data    = bus.mem_rsp_data;
    bus.busy          = (state_q != IDLE);
    bus.owner         = owner_q;
  end

endmodule

// File: tb/tb_selen_l1_mem_arb.sv
// Randomized scoreboard bench for selen_l1_mem_arb.
// Grant order and memory contents come from a transaction-level model.
module tb_selen_l1_mem_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  selen_l1_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  selen_l1_mem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mreq_t;

  typedef struct {
    bit          side;
    logic        we;
    logic [31:0] data;
  } rsp_t;

  mreq_t mem_q[$];
  rsp_t  rsp_q[$];

  logic [31:0] refmem[logic [31:0]];
  logic [31:0] phymem[logic [31:0]];

  int n_vec = 0;
  int n_err = 0;

  bit m_busy  = 1'b0;
  bit m_owner = 1'b0;
  bit m_lg    = 1'b1;

  int force_stall = -1;
  int force_dly   = -1;
  bit spur_en     = 1'b0;
  int mphase      = 0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: grant decisions and scoreboard pushes
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        bit    busy0, iv, dv, w, ei, ed;
        rsp_t  r;
        mreq_t q;
        logic [31:0] v;
        busy0 = m_busy;
        chk("busy", 64'(bus.busy), 64'(m_busy));
        chk("owner", 64'(bus.owner), 64'(m_owner));
        chk("rsp_both", 64'(bus.i_rsp_val & bus.d_rsp_val), 0);
        if (bus.i_rsp_val | bus.d_rsp_val) begin
          if (!m_busy || rsp_q.size() == 0) begin
            chk("rsp_unexpected",
                64'({bus.i_rsp_val, bus.d_rsp_val}), 0);
          end else begin
            r = rsp_q.pop_front();
            chk("rsp_side", 64'(bus.d_rsp_val), 64'(r.side));
            if (!r.we)
              chk("rsp_data",
                  64'(r.side ? bus.d_rsp_data : bus.i_rsp_data),
                  64'(r.data));
            m_busy = 1'b0;
          end
        end
        iv = bus.i_req_val;
        dv = bus.d_req_val;
        ei = 1'b0;
        ed = 1'b0;
        if (!busy0 && (iv || dv)) begin
          w  = (iv && dv) ? !m_lg : dv;
          ei = !w;
          ed = w;
        end
        chk("i_req_ack", 64'(bus.i_req_ack), 64'(ei));
        chk("d_req_ack", 64'(bus.d_req_ack), 64'(ed));
        if (ei || ed) begin
          if (ed) begin
            q.addr  = bus.d_req_addr;
            q.we    = bus.d_req_we;
            q.be    = bus.d_req_be;
            q.wdata = bus.d_req_wdata;
          end else begin
            q.addr  = bus.i_req_addr;
            q.we    = 1'b0;
            q.be    = 4'hF;
            q.wdata = 32'h0;
          end
          v = refmem.exists(q.addr) ? refmem[q.addr] : dflt(q.addr);
          r.side = ed;
          r.we   = q.we;
          r.data = v;
          if (q.we) begin
            for (int b = 0; b < 4; b++)
              if (q.be[b]) v[8*b +: 8] = q.wdata[8*b +: 8];
            refmem[q.addr] = v;
          end
          mem_q.push_back(q);
          rsp_q.push_back(r);
          m_busy  = 1'b1;
          m_owner = ed;
          m_lg    = ed;
        end
      end
    end
  end

  // Memory responder with random accept stalls and response latency
  initial begin
    bit          seen;
    int          stall, dly;
    logic [31:0] rdata, v;
    mreq_t       e;
    seen  = 1'b0;
    stall = 0;
    dly   = 0;
    rdata = 0;
    bus.mem_req_ack  = 1'b0;
    bus.mem_rsp_val  = 1'b0;
    bus.mem_rsp_data = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_req_ack = 1'b0;
      bus.mem_rsp_val = 1'b0;
      if (!rst_n) begin
        mphase = 0;
        seen   = 1'b0;
      end else if (mphase == 1) begin
        if (dly == 0) begin
          bus.mem_rsp_val  = 1'b1;
          bus.mem_rsp_data = rdata;
          mphase = 0;
        end else begin
          dly--;
        end
      end else if (bus.mem_req_val) begin
        if (mem_q.size() == 0) begin
          chk("mem_req_unexpected", 64'(bus.mem_req_val), 0);
        end else begin
          e = mem_q[0];
          chk("mem_addr", 64'(bus.mem_req_addr), 64'(e.addr));
          chk("mem_we", 64'(bus.mem_req_we), 64'(e.we));
          chk("mem_be", 64'(bus.mem_req_be), 64'(e.be));
          if (e.we)
            chk("mem_wdata", 64'(bus.mem_req_wdata), 64'(e.wdata));
        end
        if (!seen) begin
          seen  = 1'b1;
          stall = (force_stall >= 0) ? force_stall
                                     : int'($urandom_range(0, 3));
        end
        if (stall > 0) begin
          stall--;
        end else begin
          bus.mem_req_ack = 1'b1;
          seen = 1'b0;
          if (mem_q.size() != 0) void'(mem_q.pop_front());
          v = phymem.exists(bus.mem_req_addr)
            ? phymem[bus.mem_req_addr] : dflt(bus.mem_req_addr);
          if (bus.mem_req_we) begin
            for (int b = 0; b < 4; b++)
              if (bus.mem_req_be[b])
                v[8*b +: 8] = bus.mem_req_wdata[8*b +: 8];
            phymem[bus.mem_req_addr] = v;
            rdata = $urandom;
          end else begin
            rdata = v;
          end
          dly = (force_dly >= 0) ? force_dly
                                 : int'($urandom_range(0, 2));
          mphase = 1;
        end
      end else if (spur_en && $urandom_range(0, 3) == 0) begin
        bus.mem_rsp_val  = 1'b1;
        bus.mem_rsp_data = $urandom;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    mem_q.delete();
    rsp_q.delete();
    m_busy  = 1'b0;
    m_owner = 1'b0;
    m_lg    = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_owner", 64'(bus.owner), 0);
    chk("rst_mem_val", 64'(bus.mem_req_val), 0);
    chk("rst_mem_addr", 64'(bus.mem_req_addr), 0);
    chk("rst_mem_we_be", 64'({bus.mem_req_we, bus.mem_req_be}), 0);
    chk("rst_mem_wdata", 64'(bus.mem_req_wdata), 0);
    chk("rst_rsp", 64'({bus.i_rsp_val, bus.d_rsp_val}), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after grant or withdrawal
  task automatic drive_req(input bit side,
                           input logic [31:0] a,
                           input logic we,
                           input logic [3:0] be,
                           input logic [31:0] wd,
                           input bit may_wd);
    bit got, gone;
    got  = 1'b0;
    gone = 1'b0;
    if (side) begin
      bus.d_req_val   = 1'b1;
      bus.d_req_addr  = a;
      bus.d_req_we    = we;
      bus.d_req_be    = be;
      bus.d_req_wdata = wd;
    end else begin
      bus.i_req_val  = 1'b1;
      bus.i_req_addr = a;
    end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (side ? bus.d_req_ack : bus.i_req_ack) begin
        got = 1'b1;
        break;
      end
      if (may_wd && $urandom_range(0, 19) == 0) begin
        gone = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (side) begin
      bus.d_req_val   = 1'b0;
      bus.d_req_addr  = $urandom;
      bus.d_req_we    = 1'($urandom);
      bus.d_req_be    = 4'($urandom);
      bus.d_req_wdata = $urandom;
    end else begin
      bus.i_req_val  = 1'b0;
      bus.i_req_addr = $urandom;
    end
    if (!got && !gone)
      chk("req_timeout", 64'(got), 1);
  endtask

  function automatic logic [31:0] raddr();
    return 32'h1000 + (32'($urandom_range(0, 15)) << 2);
  endfunction

  task automatic gap();
    int g;
    g = $urandom_range(0, 2);
    if (g > 0) begin
      repeat (g) @(posedge clk);
      #1;
    end
  endtask

  task automatic i_stream(input int n, input bit wd);
    for (int k = 0; k < n; k++) begin
      gap();
      drive_req(1'b0, raddr(), 1'b0, 4'hF, 32'h0, wd);
    end
  endtask

  task automatic d_stream(input int n, input bit wd);
    for (int k = 0; k < n; k++) begin
      gap();
      drive_req(1'b1, raddr(), 1'($urandom), 4'($urandom),
                $urandom, wd);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      #2;
      if (!m_busy && mem_q.size() == 0 && mphase == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("idle_timeout", 64'(m_busy), 0);
  endtask

  initial begin
    bool_init();
    phymem[32'h100] = 32'hDEAD_BEEF;
    refmem[32'h100] = 32'hDEAD_BEEF;
    do_reset();

    drive_req(1'b0, 32'h100, 1'b0, 4'hF, 32'h0, 1'b0);
    wait_idle();
    drive_req(1'b1, 32'h200, 1'b1, 4'h3, 32'hA5A5_A5A5, 1'b0);
    wait_idle();
    drive_req(1'b1, 32'h200, 1'b0, 4'hF, 32'h0, 1'b0);
    wait_idle();

    do_reset();
    fork
      i_stream(2, 1'b0);
      d_stream(2, 1'b0);
    join
    wait_idle();

    force_stall = 10;
    drive_req(1'b1, 32'h300, 1'b1, 4'hC, 32'h1234_5678, 1'b0);
    wait_idle();
    force_stall = -1;

    spur_en = 1'b1;
    fork
      i_stream(60, 1'b1);
      d_stream(60, 1'b1);
    join
    wait_idle();
    spur_en = 1'b0;

    force_dly = 8;
    drive_req(1'b1, 32'h1004, 1'b0, 4'hF, 32'h0, 1'b0);
    for (int c = 0; c < 50 && mphase != 1; c++) begin
      @(posedge clk);
      #2;
    end
    @(posedge clk);
    #2;
    chk("busy_in_rsp", 64'(bus.busy), 1);
    do_reset();
    force_dly = -1;
    fork
      drive_req(1'b0, 32'h1008, 1'b0, 4'hF, 32'h0, 1'b0);
      drive_req(1'b1, 32'h100C, 1'b0, 4'hF, 32'h0, 1'b0);
    join
    wait_idle();

    spur_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    spur_en = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  task automatic bool_init();
    bus.i_req_val   = 1'b0;
    bus.i_req_addr  = 32'h0;
    bus.d_req_val   = 1'b0;
    bus.d_req_addr  = 32'h0;
    bus.d_req_we    = 1'b0;
    bus.d_req_be    = 4'h0;
    bus.d_req_wdata = 32'h0;
  endtask

endmodule
